// File: rtl/ctu_id_pkg.sv
// rtl/ctu_id_pkg.sv - shared constants, FSM encoding and VERSION image builder for ctu_idcode_ctl
package ctu_id_pkg;

    // CSR read sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_ACK  = 2'd2
    } csr_state_e;

    // IDCODE bit 0 is fixed to 1 by IEEE 1149.1
    localparam logic IDCODE_LSB = 1'b1;

    // VERSION register field positions
    localparam int VER_MANUF_LSB  = 48;
    localparam int VER_IMPL_LSB   = 32;
    localparam int VER_MAJOR_LSB  = 28;
    localparam int VER_MINOR_LSB  = 24;
    localparam int VER_MAXTL_LSB  = 8;
    localparam int VER_MAXWIN_LSB = 0;

    function automatic logic [63:0] version_image(
        input logic [15:0] manuf,
        input logic [15:0] impl,
        input logic [3:0]  major,
        input logic [3:0]  minor,
        input logic [7:0]  maxtl,
        input logic [4:0]  maxwin
    );
        logic [63:0] img;
        img = 64'h0;
        img = img | (64'(manuf)  << VER_MANUF_LSB);
        img = img | (64'(impl)   << VER_IMPL_LSB);
        img = img | (64'(major)  << VER_MAJOR_LSB);
        img = img | (64'(minor)  << VER_MINOR_LSB);
        img = img | (64'(maxtl)  << VER_MAXTL_LSB);
        img = img | (64'(maxwin) << VER_MAXWIN_LSB);
        return img;
    endfunction

endpackage

// File: rtl/ctu_idcode_ctl_if.sv
// rtl/ctu_idcode_ctl_if.sv - TAP, revision-ID and CSR read signals of ctu_idcode_ctl
interface ctu_idcode_ctl_if;

    logic [3:0]  jtag_id;
    logic [3:0]  mask_major_id;
    logic [3:0]  mask_minor_id;
    logic        tap_sel_idcode;
    logic        tap_capture_dr;
    logic        tap_shift_dr;
    logic        tap_tdi;
    logic        idcode_tdo;
    logic        idcode_shift_done;
    logic        csr_rd_req;
    logic        csr_rd_ack;
    logic [63:0] csr_rd_data;
    logic        csr_rd_drop;

    modport master (
        output jtag_id, mask_major_id, mask_minor_id,
        output tap_sel_idcode, tap_capture_dr, tap_shift_dr, tap_tdi,
        output csr_rd_req,
        input  idcode_tdo, idcode_shift_done,
        input  csr_rd_ack, csr_rd_data, csr_rd_drop
    );

    modport slave (
        input  jtag_id, mask_major_id, mask_minor_id,
        input  tap_sel_idcode, tap_capture_dr, tap_shift_dr, tap_tdi,
        input  csr_rd_req,
        output idcode_tdo, idcode_shift_done,
        output csr_rd_ack, csr_rd_data, csr_rd_drop
    );

endinterface

// File: rtl/ctu_idcode_dr.sv
// rtl/ctu_idcode_dr.sv - 32-bit IDCODE data register with shift counter and done pulse
module ctu_idcode_dr
    import ctu_id_pkg::*;
#(
    parameter logic [10:0] MANUF_ID = 11'h03e,
    parameter logic [15:0] PART_NUM = 16'h0001
) (
    input  logic       tck,
    input  logic       tap_rst,
    input  logic [3:0] jtag_id,
    input  logic       sel,
    input  logic       capture,
    input  logic       shift,
    input  logic       tdi,
    output logic       tdo,
    output logic       shift_done
);

    logic [31:0] sr;
    logic [5:0]  cnt;

    // Capture has priority over shift; the counter saturates at 32 so the done pulse fires once per capture
    always_ff @(posedge tck or posedge tap_rst) begin
        if (tap_rst) begin
            sr         <= 32'h0;
            cnt        <= 6'd0;
            shift_done <= 1'b0;
        end else begin
            shift_done <= 1'b0;
            if (sel) begin
                if (capture) begin
                    sr  <= {jtag_id, PART_NUM, MANUF_ID, IDCODE_LSB};
                    cnt <= 6'd0;
                end else if (shift) begin
                    sr <= {tdi, sr[31:1]};
                    if (cnt != 6'd32) begin
                        cnt <= cnt + 6'd1;
                    end
                    if (cnt == 6'd31) begin
                        shift_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign tdo = sr[0];

endmodule

// File: rtl/ctu_idcode_ctl.sv
// rtl/ctu_idcode_ctl.sv - revision-ID sequencer serving the TAP IDCODE register and the VERSION CSR read
module ctu_idcode_ctl
    import ctu_id_pkg::*;
#(
    parameter logic [10:0] MANUF_ID   = 11'h03e,
    parameter logic [15:0] PART_NUM   = 16'h0001,
    parameter logic [15:0] VER_MANUF  = 16'h003e,
    parameter logic [15:0] VER_IMPL   = 16'h0023,
    parameter logic [7:0]  VER_MAXTL  = 8'h06,
    parameter logic [4:0]  VER_MAXWIN = 5'h07
) (
    input  logic             tck,
    input  logic             tap_rst,
    ctu_idcode_ctl_if.slave  bus
);

    csr_state_e  state_q, state_d;
    logic        pending_q, pending_d;
    logic        ack_q, ack_d;
    logic        drop_q, drop_d;
    logic [63:0] data_q;

    ctu_idcode_dr #(
        .MANUF_ID (MANUF_ID),
        .PART_NUM (PART_NUM)
    ) u_dr (
        .tck        (tck),
        .tap_rst    (tap_rst),
        .jtag_id    (bus.jtag_id),
        .sel        (bus.tap_sel_idcode),
        .capture    (bus.tap_capture_dr),
        .shift      (bus.tap_shift_dr),
        .tdi        (bus.tap_tdi),
        .tdo        (bus.idcode_tdo),
        .shift_done (bus.idcode_shift_done)
    );

    // Next state: one request may queue behind the active one, any further request is dropped
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        drop_d    = 1'b0;
        ack_d     = (state_q == ST_ACK);
        case (state_q)
            ST_IDLE: begin
                if (bus.csr_rd_req) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                state_d = ST_ACK;
                if (bus.csr_rd_req) begin
                    if (pending_q) begin
                        drop_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (bus.csr_rd_req && pending_q) begin
                    drop_d = 1'b1;
                end
                if (pending_q || bus.csr_rd_req) begin
                    state_d   = ST_SNAP;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registered pulses and the VERSION snapshot taken while in SNAP
    always_ff @(posedge tck or posedge tap_rst) begin
        if (tap_rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            drop_q    <= 1'b0;
            data_q    <= 64'h0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            drop_q    <= drop_d;
            if (state_q == ST_SNAP) begin
                data_q <= version_image(VER_MANUF, VER_IMPL, bus.mask_major_id,
                                        bus.mask_minor_id, VER_MAXTL, VER_MAXWIN);
            end
        end
    end

    assign bus.csr_rd_ack  = ack_q;
    assign bus.csr_rd_drop = drop_q;
    assign bus.csr_rd_data = data_q;

endmodule
